// File: rtl/ball_tracker_grid_if.sv
// ---------------------------------------------------------------------------
// ball_tracker_grid_if
//   Pixel-stream bundle around the ball tracker. The source side (camera /
//   VGA timing) drives the incoming pixel and timing strobes. The tracker
//   drives the outgoing, overlaid pixel stream back toward the VGA
//   controller.
//
//   Incoming (master -> slave):
//     pix_valid      active-area pixel strobe
//     x, y           13-bit active-area column / line
//     line_end       one-cycle pulse after the last pixel of a line
//     frame_end      one-cycle pulse after the last line
//     r_in/g_in/b_in 8-bit colour components
//   Outgoing (slave -> master):
//     r_out/g_out/b_out  colour with the marker overlay, one cycle late
//     pix_valid_out      pix_valid delayed by one cycle
// ---------------------------------------------------------------------------
interface ball_tracker_grid_if;
    logic        pix_valid;
    logic [12:0] x;
    logic [12:0] y;
    logic        line_end;
    logic        frame_end;
    logic [7:0]  r_in;
    logic [7:0]  g_in;
    logic [7:0]  b_in;
    logic [7:0]  r_out;
    logic [7:0]  g_out;
    logic [7:0]  b_out;
    logic        pix_valid_out;

    modport master (
        output pix_valid, x, y, line_end, frame_end, r_in, g_in, b_in,
        input  r_out, g_out, b_out, pix_valid_out
    );

    modport slave (
        input  pix_valid, x, y, line_end, frame_end, r_in, g_in, b_in,
        output r_out, g_out, b_out, pix_valid_out
    );
endinterface

// File: rtl/ball_tracker_grid.sv
// ---------------------------------------------------------------------------
// ball_tracker_grid
//   Streaming colour-blob tracker. Each active pixel is classified as
//   "target green". Hits are counted per BLOCK x BLOCK grid cell of the
//   current block row. The GRID_COLS counters are scanned during the
//   horizontal blanking that follows the last line of every block row, and
//   the running best cell is committed at frame end. The committed cell is
//   painted with MARK_RGB in the outgoing video, which has one cycle of
//   latency.
//
// Ports:
//   CLK, reset     clock; synchronous active-high reset
//   enable         0 = registered passthrough, no accumulation, no commits
//   vid            pixel stream in/out (ball_tracker_grid_if.slave)
//   ball_valid     committed detection valid
//   ball_col/row   committed cell coordinates
//   ball_count     hit count of the committed cell
//   frame_done     one-cycle pulse when a commit happens
//   overrun        sticky: a pixel arrived while scanning/committing
//
// Optional build macro BALL_TRACKER_HOLD_EN: keep the last position valid
// through up to HOLD_FRAMES-1 consecutive failed commits.
// ---------------------------------------------------------------------------
module ball_tracker_grid #(
    parameter int          GRID_COLS   = 40,
    parameter int          GRID_ROWS   = 30,
    parameter int          BLOCK       = 16,
    parameter int          CNT_W       = 9,
    parameter int          G_MARGIN    = 32,
    parameter int          G_MIN       = 64,
    parameter int          MIN_COUNT   = 9,
    parameter int          HOLD_FRAMES = 4,
    parameter logic [23:0] MARK_RGB    = 24'h000000
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         enable,
    ball_tracker_grid_if.slave           vid,
    output logic                         ball_valid,
    output logic [$clog2(GRID_COLS)-1:0] ball_col,
    output logic [$clog2(GRID_ROWS)-1:0] ball_row,
    output logic [CNT_W-1:0]             ball_count,
    output logic                         frame_done,
    output logic                         overrun
);
    localparam int SH    = $clog2(BLOCK);
    localparam int COL_W = $clog2(GRID_COLS);
    localparam int ROW_W = $clog2(GRID_ROWS);

    // Elaboration-time sanity check of the parameter set.
    if (HOLD_FRAMES < 1 || (BLOCK & (BLOCK - 1)) != 0 || BLOCK < 2 ||
        (1 << CNT_W) <= BLOCK * BLOCK) begin : g_param_check
        $error("ball_tracker_grid: invalid parameter combination");
    end

    typedef enum logic [1:0] {ACCUM, SCAN, COMMIT} state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt [GRID_COLS];
    logic [COL_W-1:0]   scan_idx;
    logic [ROW_W-1:0]   scan_row;
    logic               frame_pend;
    logic [CNT_W-1:0]   best_cnt;
    logic [COL_W-1:0]   best_col;
    logic [ROW_W-1:0]   best_row;

`ifdef BALL_TRACKER_HOLD_EN
    localparam int MISS_W = $clog2(HOLD_FRAMES + 1);
    logic [MISS_W-1:0]  miss_cnt;
`endif

    // Target test in 9 bits so r/b + margin cannot wrap.
    function automatic logic is_target(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
        logic [8:0] r9, g9, b9;
        r9 = {1'b0, r};
        g9 = {1'b0, g};
        b9 = {1'b0, b};
        return (g9 >= r9 + 9'(G_MARGIN)) && (g9 >= b9 + 9'(G_MARGIN)) &&
               (g9 >= 9'(G_MIN));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic [12:0]      pix_col;
    logic [12:0]      pix_row;
    logic [COL_W-1:0] hit_col;
    logic             in_grid;
    logic             hit;
    logic             row_last;
    logic             scan_start;
    logic             scan_last;
    logic             in_mark;

    assign pix_col    = vid.x >> SH;
    assign pix_row    = vid.y >> SH;
    assign hit_col    = pix_col[COL_W-1:0];
    assign in_grid    = (vid.x < 13'(GRID_COLS * BLOCK)) && (vid.y < 13'(GRID_ROWS * BLOCK));
    assign hit        = enable && (state == ACCUM) && vid.pix_valid && in_grid &&
                        is_target(vid.r_in, vid.g_in, vid.b_in);
    // line_end closes a block row when the line just finished is the last
    // line of a cell and still inside the grid.
    assign row_last   = (vid.y[SH-1:0] == '1) && (pix_row < 13'(GRID_ROWS));
    assign scan_start = (state == ACCUM) && vid.line_end && row_last;
    assign scan_last  = (scan_idx == COL_W'(GRID_COLS - 1));
    assign in_mark    = ball_valid && vid.pix_valid &&
                        (pix_col == 13'(ball_col)) && (pix_row == 13'(ball_row));

    always_ff @(posedge CLK) begin
        if (reset) state <= ACCUM;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ACCUM: begin
                if (vid.line_end && row_last) state_nx = SCAN;
                else if (vid.frame_end)       state_nx = COMMIT;
            end
            SCAN: begin
                if (scan_last) state_nx = (frame_pend || vid.frame_end) ? COMMIT : ACCUM;
            end
            COMMIT:  state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
        if (!enable) state_nx = ACCUM;
    end

    // A frame_end that lands while a scan is pending or running is
    // remembered and turned into a commit once the scan finishes.
    always_ff @(posedge CLK) begin
        if (reset || !enable) begin
            frame_pend <= 1'b0;
        end else if (scan_start) begin
            frame_pend <= vid.frame_end;
        end else if (state == SCAN) begin
            if (scan_last)          frame_pend <= 1'b0;
            else if (vid.frame_end) frame_pend <= 1'b1;
        end
    end

    // Per-column hit counters for the current block row. The scan clears
    // each entry as it reads it, leaving the row empty for the next block row.
    always_ff @(posedge CLK) begin
        if (reset || !enable) begin
            for (int i = 0; i < GRID_COLS; i++) cnt[i] <= '0;
        end else if (state == SCAN) begin
            cnt[scan_idx] <= '0;
        end else if (hit) begin
            cnt[hit_col] <= sat_inc(cnt[hit_col]);
        end
    end

    // Running best over the frame. Strict '>' keeps the earliest cell on ties.
    always_ff @(posedge CLK) begin
        if (reset || !enable) begin
            scan_idx <= '0;
            scan_row <= '0;
            best_cnt <= '0;
            best_col <= '0;
            best_row <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (scan_start) begin
                        scan_idx <= '0;
                        scan_row <= pix_row[ROW_W-1:0];
                    end
                end
                SCAN: begin
                    if (cnt[scan_idx] > best_cnt) begin
                        best_cnt <= cnt[scan_idx];
                        best_col <= scan_idx;
                        best_row <= scan_row;
                    end
                    scan_idx <= scan_idx + COL_W'(1);
                end
                COMMIT:  best_cnt <= '0;
                default: ;
            endcase
        end
    end

    // Commit of the frame result, and the sticky overrun flag.
    always_ff @(posedge CLK) begin
        if (reset) begin
            ball_valid <= 1'b0;
            ball_col   <= '0;
            ball_row   <= '0;
            ball_count <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
`ifdef BALL_TRACKER_HOLD_EN
            miss_cnt   <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (enable && (state != ACCUM) && vid.pix_valid) overrun <= 1'b1;
            if (enable && (state == COMMIT)) begin
                frame_done <= 1'b1;
                if (best_cnt >= CNT_W'(MIN_COUNT)) begin
                    ball_valid <= 1'b1;
                    ball_col   <= best_col;
                    ball_row   <= best_row;
                    ball_count <= best_cnt;
`ifdef BALL_TRACKER_HOLD_EN
                    miss_cnt   <= '0;
`endif
                end else begin
`ifdef BALL_TRACKER_HOLD_EN
                    // Position holds; validity survives until the
                    // HOLD_FRAMES-th consecutive miss.
                    if (miss_cnt < MISS_W'(HOLD_FRAMES)) miss_cnt <= miss_cnt + MISS_W'(1);
                    if (int'(miss_cnt) + 1 >= HOLD_FRAMES) ball_valid <= 1'b0;
`else
                    ball_valid <= 1'b0;
`endif
                end
            end
        end
    end

    // Video path: one register stage, marker painted over the committed cell.
    always_ff @(posedge CLK) begin
        if (reset) begin
            vid.pix_valid_out <= 1'b0;
            vid.r_out         <= '0;
            vid.g_out         <= '0;
            vid.b_out         <= '0;
        end else begin
            vid.pix_valid_out <= vid.pix_valid;
            if (enable && in_mark) begin
                {vid.r_out, vid.g_out, vid.b_out} <= MARK_RGB;
            end else begin
                vid.r_out <= vid.r_in;
                vid.g_out <= vid.g_in;
                vid.b_out <= vid.b_in;
            end
        end
    end

endmodule

// File: tb/tb_ball_tracker_grid.sv
// ---------------------------------------------------------------------------
// tb_ball_tracker_grid
//   Directed bench for ball_tracker_grid on a 4x3 grid of 4x4-pixel cells
//   (16x12 active pixels, 8-cycle horizontal blanking). Each frame is built
//   from a per-cell hit table; expected detections are hand-computed
//   constants, and the overlay is checked on every pixel.
// ---------------------------------------------------------------------------
module tb_ball_tracker_grid;
    localparam logic [23:0] GREY = 24'h646464;
    localparam logic [23:0] MARK = 24'h000000;
`ifdef BALL_TRACKER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       reset;
    logic       enable;
    logic       ball_valid;
    logic [1:0] ball_col;
    logic [1:0] ball_row;
    logic [8:0] ball_count;
    logic       frame_done;
    logic       overrun;

    int    n_cmp  = 0;
    int    n_bad  = 0;
    int    fd_cnt = 0;
    string step   = "reset";

    int         hits [3][4];
    logic [7:0] hr   [3][4];
    logic [7:0] hg   [3][4];
    logic [7:0] hb   [3][4];
    logic       mk_v = 1'b0;
    int         mk_c = 0;
    int         mk_r = 0;

    ball_tracker_grid_if vid ();

    ball_tracker_grid #(
        .GRID_COLS(4), .GRID_ROWS(3), .BLOCK(4), .CNT_W(9),
        .G_MARGIN(32), .G_MIN(64), .MIN_COUNT(9), .HOLD_FRAMES(4),
        .MARK_RGB(24'h000000)
    ) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .vid(vid),
        .ball_valid(ball_valid), .ball_col(ball_col), .ball_row(ball_row),
        .ball_count(ball_count), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (frame_done === 1'b1) fd_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
        end
    endtask

    task automatic clear_map();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                hits[r][c] = 0;
                hr[r][c] = 8'd0;
                hg[r][c] = 8'd200;
                hb[r][c] = 8'd0;
            end
        end
    endtask

    task automatic set_cell(input int c, input int r, input int n,
                            input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        hits[r][c] = n;
        hr[r][c]   = rr;
        hg[r][c]   = gg;
        hb[r][c]   = bb;
    endtask

    // The first n pixels (raster order inside the cell) of a cell are targets.
    function automatic logic [23:0] pix_rgb(input int xx, input int yy);
        int c, r, k;
        c = xx / 4;
        r = yy / 4;
        k = (yy % 4) * 4 + (xx % 4);
        if (k < hits[r][c]) return {hr[r][c], hg[r][c], hb[r][c]};
        return GREY;
    endfunction

    task automatic send_line(input int yy, input int nblank, input int fe_at, input bit inject);
        logic [23:0] rgb;
        logic [23:0] ex;
        bit          mark;
        for (int xx = 0; xx < 16; xx++) begin
            rgb = pix_rgb(xx, yy);
            vid.pix_valid = 1'b1;
            vid.x = 13'(xx);
            vid.y = 13'(yy);
            {vid.r_in, vid.g_in, vid.b_in} = rgb;
            tick();
            mark = enable && mk_v && (xx / 4 == mk_c) && (yy / 4 == mk_r);
            ex = mark ? MARK : rgb;
            chk("rgb_out", 32'({vid.r_out, vid.g_out, vid.b_out}), 32'(ex));
            chk("pix_valid_out", 32'(vid.pix_valid_out), 32'd1);
        end
        vid.pix_valid = 1'b0;
        {vid.r_in, vid.g_in, vid.b_in} = GREY;
        vid.line_end = 1'b1;
        tick();
        vid.line_end = 1'b0;
        chk("blank_valid", 32'(vid.pix_valid_out), 32'd0);
        chk("blank_rgb", 32'({vid.r_out, vid.g_out, vid.b_out}), 32'(GREY));
        for (int b = 0; b < nblank; b++) begin
            if (inject && b == 1) begin
                vid.pix_valid = 1'b1;
                vid.x = 13'd12;
                vid.y = 13'(yy);
                {vid.r_in, vid.g_in, vid.b_in} = 24'h00C800;
            end
            if (b == fe_at) vid.frame_end = 1'b1;
            tick();
            vid.pix_valid = 1'b0;
            vid.frame_end = 1'b0;
            {vid.r_in, vid.g_in, vid.b_in} = GREY;
        end
    endtask

    task automatic run_frame(input bit fe_early, input int inj_y, input int exp_fd);
        int fd0;
        fd0 = fd_cnt;
        for (int yy = 0; yy < 12; yy++)
            send_line(yy, 7, (yy == 11) ? (fe_early ? 0 : 6) : -1, yy == inj_y);
        repeat (6) tick();
        chk("frame_done_count", 32'(fd_cnt - fd0), 32'(exp_fd));
    endtask

    task automatic check_ball(input logic v, input int c, input int r, input int n);
        chk("ball_valid", 32'(ball_valid), 32'(v));
        chk("ball_col", 32'(ball_col), 32'(c));
        chk("ball_row", 32'(ball_row), 32'(r));
        chk("ball_count", 32'(ball_count), 32'(n));
        mk_v = v;
        mk_c = c;
        mk_r = r;
    endtask

    task automatic check_all_zero();
        chk("z_rgb", 32'({vid.r_out, vid.g_out, vid.b_out}), 32'd0);
        chk("z_pix_valid_out", 32'(vid.pix_valid_out), 32'd0);
        chk("z_ball_valid", 32'(ball_valid), 32'd0);
        chk("z_ball_col", 32'(ball_col), 32'd0);
        chk("z_ball_row", 32'(ball_row), 32'd0);
        chk("z_ball_count", 32'(ball_count), 32'd0);
        chk("z_frame_done", 32'(frame_done), 32'd0);
        chk("z_overrun", 32'(overrun), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        vid.pix_valid = 1'b0;
        vid.x = '0;
        vid.y = '0;
        vid.line_end = 1'b0;
        vid.frame_end = 1'b0;
        {vid.r_in, vid.g_in, vid.b_in} = GREY;
        tick();
        tick();
        check_all_zero();
        reset = 1'b0;
        tick();

        // Basic detection: 10 hits in cell (2,1).
        step = "A";
        clear_map();
        set_cell(2, 1, 10, 8'd0, 8'd200, 8'd0);
        run_frame(1'b0, -1, 1);
        check_ball(1'b1, 2, 1, 10);
        chk("overrun", 32'(overrun), 32'd0);

        // Tie at 12: row 0 beats row 2. Marker on (2,1) checked during frame.
        step = "B";
        clear_map();
        set_cell(1, 0, 12, 8'd0, 8'd200, 8'd0);
        set_cell(3, 2, 12, 8'd0, 8'd200, 8'd0);
        run_frame(1'b0, -1, 1);
        check_ball(1'b1, 1, 0, 12);

        // A full cell: 16 hits, no saturation.
        step = "C";
        clear_map();
        set_cell(0, 0, 16, 8'd0, 8'd200, 8'd0);
        run_frame(1'b0, -1, 1);
        check_ball(1'b1, 0, 0, 16);

        // Colour thresholds: margin 31 and g=60 rejected, margin 32 accepted.
        step = "D";
        clear_map();
        set_cell(0, 0, 16, 8'd64, 8'd95, 8'd0);
        set_cell(1, 1, 10, 8'd64, 8'd96, 8'd0);
        set_cell(2, 2, 16, 8'd0,  8'd60, 8'd0);
        run_frame(1'b0, -1, 1);
        check_ball(1'b1, 1, 1, 10);

        // 8 hits: below MIN_COUNT, position held.
        step = "E";
        clear_map();
        set_cell(3, 2, 8, 8'd0, 8'd200, 8'd0);
        run_frame(1'b0, -1, 1);
        check_ball(HOLD, 1, 1, 10);

        step = "F";
        clear_map();
        set_cell(2, 1, 10, 8'd0, 8'd200, 8'd0);
        run_frame(1'b0, -1, 1);
        check_ball(1'b1, 2, 1, 10);

        // Four empty frames after a hit.
        for (int i = 0; i < 4; i++) begin
            step = $sformatf("empty%0d", i);
            clear_map();
            run_frame(1'b0, -1, 1);
            check_ball(HOLD && (i < 3), 2, 1, 10);
        end
        chk("overrun_before", 32'(overrun), 32'd0);

        // Pixel injected 2 cycles after the block-row line_end of line 3,
        // into column 3 (not yet scanned); 8 + 1 would reach MIN_COUNT.
        step = "G";
        clear_map();
        set_cell(3, 0, 8, 8'd0, 8'd200, 8'd0);
        run_frame(1'b0, 3, 1);
        check_ball(1'b0, 2, 1, 10);
        chk("overrun_set", 32'(overrun), 32'd1);

        // frame_end during the last scan; exactly MIN_COUNT hits in row 2.
        step = "H";
        clear_map();
        set_cell(1, 2, 9, 8'd0, 8'd200, 8'd0);
        run_frame(1'b1, -1, 1);
        check_ball(1'b1, 1, 2, 9);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Reset while the block-row-0 scan is running.
        step = "RST";
        clear_map();
        set_cell(0, 0, 16, 8'd0, 8'd200, 8'd0);
        for (int yy = 0; yy < 3; yy++) send_line(yy, 7, -1, 1'b0);
        send_line(3, 1, -1, 1'b0);
        reset = 1'b1;
        tick();
        check_all_zero();
        reset = 1'b0;
        mk_v = 1'b0;
        repeat (4) tick();

        step = "I";
        clear_map();
        set_cell(3, 1, 11, 8'd0, 8'd200, 8'd0);
        run_frame(1'b0, -1, 1);
        check_ball(1'b1, 3, 1, 11);
        chk("overrun_after_reset", 32'(overrun), 32'd0);

        // enable=0: passthrough, no commit, position held.
        step = "J";
        enable = 1'b0;
        clear_map();
        set_cell(0, 2, 16, 8'd0, 8'd200, 8'd0);
        run_frame(1'b0, -1, 0);
        check_ball(1'b1, 3, 1, 11);

        step = "K";
        enable = 1'b1;
        clear_map();
        set_cell(2, 0, 10, 8'd0, 8'd200, 8'd0);
        run_frame(1'b0, -1, 1);
        check_ball(1'b1, 2, 0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
